// File: rtl/ps2_scancode_rx_pkg.sv
// rtl/ps2_scancode_rx_pkg.sv - shared types and constants for the PS/2 scan code receiver
package ps2_scancode_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef struct packed {
    logic       pressed;
    logic       extended;
    logic [7:0] code;
  } key_event_t;

  // PS/2 frames carry odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-flop synchronizer, glitch filter and falling-edge detect for ps2_clk
module ps2_line_filter #(
  parameter int FILTER_CYCLES = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic fall
);

  localparam int CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  // A new level is taken only after FILTER_CYCLES consecutive samples disagree with the current one.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        fall  <= level & ~sync2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// rtl/ps2_scancode_rx.sv - PS/2 keyboard frame receiver decoding make/break/extended scan codes
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int FILTER_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       pressed,
  output logic       extended,
  output logic       valid,
  output logic       frame_err
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic            fall;
  logic            data_s1;
  logic            data_s2;
  ps2_state_t      state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic [WD_W-1:0] wdog;
  logic            break_flag;
  logic            ext_flag;
  key_event_t      ev;

  ps2_line_filter #(
    .FILTER_CYCLES(FILTER_CYCLES)
  ) u_clk_filter (
    .clk  (clk),
    .reset(reset),
    .din  (ps2_clk),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // wdog holds the number of cycles since the last fall event; a timeout wins over a coincident fall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      wdog       <= '0;
      break_flag <= 1'b0;
      ext_flag   <= 1'b0;
      ev         <= '0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      if (state != ST_IDLE && wdog == WD_LAST) begin
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        shift      <= '0;
        wdog       <= '0;
        break_flag <= 1'b0;
        ext_flag   <= 1'b0;
        frame_err  <= 1'b1;
      end else if (fall) begin
        wdog <= WD_W'(1);
        case (state)
          ST_IDLE: begin
            if (!data_s2) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              wdog <= '0;
            end
          end
          ST_DATA: begin
            shift <= {data_s2, shift[7:1]};
            if (bit_cnt == 3'd7) begin
              state <= ST_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
          ST_PARITY: begin
            parity_bit <= data_s2;
            state      <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            wdog  <= '0;
            if (data_s2 && odd_parity_ok(shift, parity_bit)) begin
              if (shift == PS2_BREAK) begin
                break_flag <= 1'b1;
              end else if (shift == PS2_EXT) begin
                ext_flag <= 1'b1;
              end else begin
                ev.code     <= shift;
                ev.pressed  <= ~break_flag;
                ev.extended <= ext_flag;
                valid       <= 1'b1;
                break_flag  <= 1'b0;
                ext_flag    <= 1'b0;
              end
            end else begin
              frame_err  <= 1'b1;
              break_flag <= 1'b0;
              ext_flag   <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        wdog <= wdog + WD_W'(1);
      end
    end
  end

  assign code     = ev.code;
  assign pressed  = ev.pressed;
  assign extended = ev.extended;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb/tb_ps2_scancode_rx.sv - directed self-checking bench for ps2_scancode_rx
module tb_ps2_scancode_rx;

  localparam int FILT = 4;
  localparam int TMO  = 1000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       pressed;
  logic       extended;
  logic       valid;
  logic       frame_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_valid_cyc = 0;
  int last_err_cyc = 0;
  int fall_cyc = 0;

  ps2_scancode_rx #(
    .FILTER_CYCLES (FILT),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .code     (code),
    .pressed  (pressed),
    .extended (extended),
    .valid    (valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
    if (frame_err) begin
      err_cnt      <= err_cnt + 1;
      last_err_cyc <= cyc;
    end
    if (valid && frame_err) both_cnt <= both_cnt + 1;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    wait_cycles(HALF / 2);
    ps2_clk  = 1'b0;
    fall_cyc = cyc;
    wait_cycles(HALF);
    ps2_clk = 1'b1;
    wait_cycles(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(~(^b) ^ flip_parity);
    send_bit(1'b1);
    wait_cycles(10);
  endtask

  task automatic check_event(input string name, input int v0, input int e0, input logic [7:0] c,
                             input logic p, input logic x);
    checks++;
    if (valid_cnt !== v0 + 1) begin
      failures++;
      $display("FAIL %s valid_count got=%0d want=%0d", name, valid_cnt - v0, 1);
    end
    checks++;
    if (err_cnt !== e0) begin
      failures++;
      $display("FAIL %s frame_err_count got=%0d want=0", name, err_cnt - e0);
    end
    checks++;
    if ({code, pressed, extended} !== {c, p, x}) begin
      failures++;
      $display("FAIL %s event got=%h/%b/%b want=%h/%b/%b", name, code, pressed, extended, c, p, x);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    wait_cycles(5);
    checks++;
    if ({code, pressed, extended, valid, frame_err} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b/%b/%b/%b want=00/0/0/0/0", code, pressed, extended,
               valid, frame_err);
    end
    reset = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_make();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'h15, 1'b0);
    check_event("make_15", v0, e0, 8'h15, 1'b1, 1'b0);
    checks++;
    if (last_valid_cyc - fall_cyc !== FILT + 3) begin
      failures++;
      $display("FAIL valid_latency got=%0d want=%0d", last_valid_cyc - fall_cyc, FILT + 3);
    end
  endtask

  task automatic test_break();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'hF0, 1'b0);
    checks++;
    if (valid_cnt !== v0) begin
      failures++;
      $display("FAIL break_prefix_valid got=%0d want=0", valid_cnt - v0);
    end
    send_frame(8'h1D, 1'b0);
    check_event("break_1d", v0, e0, 8'h1D, 1'b0, 1'b0);
  endtask

  task automatic test_extended();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    check_event("ext_break_75", v0, e0, 8'h75, 1'b0, 1'b1);
    v0 = valid_cnt;
    send_frame(8'h75, 1'b0);
    check_event("make_75_after", v0, e0, 8'h75, 1'b1, 1'b0);
  endtask

  task automatic test_parity_err();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1D, 1'b1);
    checks++;
    if (err_cnt !== e0 + 1 || valid_cnt !== v0) begin
      failures++;
      $display("FAIL parity_err got=err%0d/valid%0d want=err1/valid0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if (code !== 8'h75) begin
      failures++;
      $display("FAIL parity_code_hold got=%h want=75", code);
    end
    e0 = err_cnt;
    send_frame(8'h24, 1'b0);
    check_event("after_parity_24", v0, e0, 8'h24, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    int t = 0;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    while (err_cnt == e0 && t < TMO + 200) begin
      @(negedge clk);
      t++;
    end
    wait_cycles(5);
    checks++;
    if (err_cnt !== e0 + 1 || valid_cnt !== v0) begin
      failures++;
      $display("FAIL timeout_err got=err%0d/valid%0d want=err1/valid0", err_cnt - e0, valid_cnt - v0);
    end
    checks++;
    if (last_err_cyc - fall_cyc !== FILT + 2 + TMO) begin
      failures++;
      $display("FAIL timeout_delay got=%0d want=%0d", last_err_cyc - fall_cyc, FILT + 2 + TMO);
    end
    e0 = err_cnt;
    send_frame(8'h2D, 1'b0);
    check_event("after_timeout_2d", v0, e0, 8'h2D, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(TMO + 50);
    checks++;
    if (err_cnt !== e0 || valid_cnt !== v0) begin
      failures++;
      $display("FAIL reset_midframe got=err%0d/valid%0d want=err0/valid0", err_cnt - e0,
               valid_cnt - v0);
    end
    checks++;
    if (code !== 8'h00) begin
      failures++;
      $display("FAIL reset_midframe_code got=%h want=00", code);
    end
    send_frame(8'h43, 1'b0);
    check_event("after_reset_43", v0, e0, 8'h43, 1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int e0 = err_cnt;
    @(negedge clk);
    ps2_data = 1'b0;
    wait_cycles(5);
    ps2_clk = 1'b0;
    wait_cycles(2);
    ps2_clk = 1'b1;
    wait_cycles(20);
    ps2_data = 1'b1;
    wait_cycles(5);
    send_frame(8'h1C, 1'b0);
    check_event("glitch_then_1c", v0, e0, 8'h1C, 1'b1, 1'b0);
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_cnt !== 0) begin
      failures++;
      $display("FAIL valid_err_overlap got=%0d want=0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_parity_err();
    test_timeout();
    test_reset_midframe();
    test_glitch();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
